// File: rtl/qerv_arb_pkg.sv
// Shared types for the ibus/dbus Wishbone arbiter.
//   state_t : grant FSM states
//   grant_t : which master owned the last completed transfer
//   IBUS_SEL: byte selects presented to memory for instruction fetches
package qerv_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IBUS = 2'd1,
        DBUS = 2'd2
    } state_t;

    typedef enum logic {
        G_IBUS = 1'b0,
        G_DBUS = 1'b1
    } grant_t;

    localparam logic [3:0] IBUS_SEL = 4'hf;

endpackage

// File: rtl/qerv_arb_timer.sv
// Bus-cycle watchdog for the arbiter.
// Counts cycles in which a memory cycle is outstanding without ack and
// flags expiry when the count reaches TIMEOUT-1 with still no ack.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_busy       : a granted memory cycle is outstanding
//   i_ack        : memory ack for the outstanding cycle
//   o_expired    : combinational, asserted in the cycle the arbiter must force-terminate
module qerv_arb_timer #(
    parameter int TIMEOUT = 1023
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_busy,
    input  logic i_ack,
    output logic o_expired
);

    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    assign o_expired = i_busy & ~i_ack & (count == LAST);

    // Cleared whenever nothing is outstanding (IDLE or abort), on ack,
    // and on expiry so the next grant starts from zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            count <= '0;
        else if (~i_busy | i_ack | o_expired)
            count <= '0;
        else
            count <= count + 1'b1;
    end

endmodule

// File: rtl/qerv_bus_arbiter.sv
// Shares one Wishbone memory port between the core's instruction bus and
// data bus. A registered grant FSM (IDLE/IBUS/DBUS) selects the master;
// the memory-side mux follows the state only, so a new request is seen on
// memory one cycle after it is raised in IDLE. A grant is held until ack
// (or abort) and every transfer is followed by one IDLE bubble.
// Optional build macro QERV_ARB_TIMEOUT_EN adds a watchdog that
// force-terminates a cycle after TIMEOUT cycles without ack.
// Ports:
//   i_clk, i_rst            : clock, asynchronous active-high reset
//   i_wb_ibus_* / o_wb_ibus_*: instruction master (read-only)
//   i_wb_dbus_* / o_wb_dbus_*: data master
//   o_wb_mem_* / i_wb_mem_*  : shared memory port
//   o_timeout               : one-cycle pulse on forced termination
module qerv_bus_arbiter
    import qerv_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter bit RR      = 1'b1,
    parameter int TIMEOUT = 1023
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [AW-1:0] i_wb_ibus_adr,
    input  logic          i_wb_ibus_cyc,
    output logic [31:0]   o_wb_ibus_rdt,
    output logic          o_wb_ibus_ack,
    input  logic [AW-1:0] i_wb_dbus_adr,
    input  logic [31:0]   i_wb_dbus_dat,
    input  logic [3:0]    i_wb_dbus_sel,
    input  logic          i_wb_dbus_we,
    input  logic          i_wb_dbus_cyc,
    output logic [31:0]   o_wb_dbus_rdt,
    output logic          o_wb_dbus_ack,
    output logic [AW-1:0] o_wb_mem_adr,
    output logic [31:0]   o_wb_mem_dat,
    output logic [3:0]    o_wb_mem_sel,
    output logic          o_wb_mem_we,
    output logic          o_wb_mem_cyc,
    input  logic [31:0]   i_wb_mem_rdt,
    input  logic          i_wb_mem_ack,
    output logic          o_timeout
);

    state_t state;
    grant_t last_grant;

    logic ibus_gnt, dbus_gnt;
    logic cyc_raw, ack_raw, expired, done;

    assign ibus_gnt = (state == IBUS);
    assign dbus_gnt = (state == DBUS);

    // Cycle is live only while the granted master keeps its cyc high;
    // a stray memory ack outside such a cycle never reaches a master.
    assign cyc_raw = (ibus_gnt & i_wb_ibus_cyc) | (dbus_gnt & i_wb_dbus_cyc);
    assign ack_raw = i_wb_mem_ack & cyc_raw;

`ifdef QERV_ARB_TIMEOUT_EN
    qerv_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_busy    (cyc_raw),
        .i_ack     (i_wb_mem_ack),
        .o_expired (expired)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT == 0);
    assign expired = 1'b0;
`endif

    assign done      = ack_raw | expired;
    assign o_timeout = expired;

    // Memory side: steered purely by state. IDLE presents the ibus shape
    // with cyc low, which memory ignores.
    assign o_wb_mem_cyc = cyc_raw & ~expired;
    assign o_wb_mem_adr = dbus_gnt ? i_wb_dbus_adr : i_wb_ibus_adr;
    assign o_wb_mem_dat = dbus_gnt ? i_wb_dbus_dat : 32'h0;
    assign o_wb_mem_sel = dbus_gnt ? i_wb_dbus_sel : IBUS_SEL;
    assign o_wb_mem_we  = dbus_gnt & i_wb_dbus_we;

    // Master side: a forced termination returns zero data.
    assign o_wb_ibus_ack = ibus_gnt & done;
    assign o_wb_dbus_ack = dbus_gnt & done;
    assign o_wb_ibus_rdt = (ibus_gnt & ~expired) ? i_wb_mem_rdt : 32'h0;
    assign o_wb_dbus_rdt = (dbus_gnt & ~expired) ? i_wb_mem_rdt : 32'h0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            last_grant <= G_IBUS;
        end else begin
            case (state)
                IDLE: begin
                    if (i_wb_ibus_cyc & i_wb_dbus_cyc) begin
                        if (RR)
                            state <= (last_grant == G_IBUS) ? DBUS : IBUS;
                        else
                            state <= DBUS;
                    end else if (i_wb_dbus_cyc) begin
                        state <= DBUS;
                    end else if (i_wb_ibus_cyc) begin
                        state <= IBUS;
                    end
                end
                IBUS: begin
                    // Abort leaves last_grant untouched.
                    if (!i_wb_ibus_cyc) begin
                        state <= IDLE;
                    end else if (done) begin
                        state      <= IDLE;
                        last_grant <= G_IBUS;
                    end
                end
                DBUS: begin
                    if (!i_wb_dbus_cyc) begin
                        state <= IDLE;
                    end else if (done) begin
                        state      <= IDLE;
                        last_grant <= G_DBUS;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qerv_bus_arbiter.sv
// Directed bench for qerv_bus_arbiter. Two instances share all inputs:
// u_dut (RR=1) and u_rr0 (RR=0, fixed dbus priority). Inputs change 1ns
// after a rising edge; outputs are checked 1ns later, before the next edge.
// The watchdog section is compiled only with QERV_ARB_TIMEOUT_EN.
module tb_qerv_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ibus_adr;
    logic        ibus_cyc;
    logic [31:0] dbus_adr;
    logic [31:0] dbus_dat;
    logic [3:0]  dbus_sel;
    logic        dbus_we;
    logic        dbus_cyc;
    logic [31:0] mem_rdt;
    logic        mem_ack;

    logic [31:0] ibus_rdt, dbus_rdt, mem_adr, mem_dat;
    logic        ibus_ack, dbus_ack, mem_we, mem_cyc, tmo;
    logic [3:0]  mem_sel;

    logic [31:0] r0_ibus_rdt, r0_dbus_rdt, r0_mem_adr, r0_mem_dat;
    logic        r0_ibus_ack, r0_dbus_ack, r0_mem_we, r0_mem_cyc, r0_tmo;
    logic [3:0]  r0_mem_sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    qerv_bus_arbiter #(.AW(32), .RR(1'b1), .TIMEOUT(8)) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_wb_ibus_adr(ibus_adr), .i_wb_ibus_cyc(ibus_cyc),
        .o_wb_ibus_rdt(ibus_rdt), .o_wb_ibus_ack(ibus_ack),
        .i_wb_dbus_adr(dbus_adr), .i_wb_dbus_dat(dbus_dat),
        .i_wb_dbus_sel(dbus_sel), .i_wb_dbus_we(dbus_we),
        .i_wb_dbus_cyc(dbus_cyc),
        .o_wb_dbus_rdt(dbus_rdt), .o_wb_dbus_ack(dbus_ack),
        .o_wb_mem_adr(mem_adr), .o_wb_mem_dat(mem_dat),
        .o_wb_mem_sel(mem_sel), .o_wb_mem_we(mem_we),
        .o_wb_mem_cyc(mem_cyc),
        .i_wb_mem_rdt(mem_rdt), .i_wb_mem_ack(mem_ack),
        .o_timeout(tmo)
    );

    qerv_bus_arbiter #(.AW(32), .RR(1'b0), .TIMEOUT(8)) u_rr0 (
        .i_clk(clk), .i_rst(rst),
        .i_wb_ibus_adr(ibus_adr), .i_wb_ibus_cyc(ibus_cyc),
        .o_wb_ibus_rdt(r0_ibus_rdt), .o_wb_ibus_ack(r0_ibus_ack),
        .i_wb_dbus_adr(dbus_adr), .i_wb_dbus_dat(dbus_dat),
        .i_wb_dbus_sel(dbus_sel), .i_wb_dbus_we(dbus_we),
        .i_wb_dbus_cyc(dbus_cyc),
        .o_wb_dbus_rdt(r0_dbus_rdt), .o_wb_dbus_ack(r0_dbus_ack),
        .o_wb_mem_adr(r0_mem_adr), .o_wb_mem_dat(r0_mem_dat),
        .o_wb_mem_sel(r0_mem_sel), .o_wb_mem_we(r0_mem_we),
        .o_wb_mem_cyc(r0_mem_cyc),
        .i_wb_mem_rdt(mem_rdt), .i_wb_mem_ack(mem_ack),
        .o_timeout(r0_tmo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ibus_adr = '0; ibus_cyc = 1'b0;
        dbus_adr = '0; dbus_dat = '0; dbus_sel = '0; dbus_we = 1'b0; dbus_cyc = 1'b0;
        mem_rdt = '0; mem_ack = 1'b0;
        #2;
        chk("rst_cyc",      {31'd0, mem_cyc},  32'd0);
        chk("rst_iack",     {31'd0, ibus_ack}, 32'd0);
        chk("rst_dack",     {31'd0, dbus_ack}, 32'd0);
        chk("rst_tmo",      {31'd0, tmo},      32'd0);

        // Stray memory ack in IDLE
        tick;
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdt = 32'h5555aaaa;
        #1;
        chk("stray_iack",   {31'd0, ibus_ack}, 32'd0);
        chk("stray_dack",   {31'd0, dbus_ack}, 32'd0);
        chk("stray_cyc",    {31'd0, mem_cyc},  32'd0);
        tick;
        mem_ack = 1'b0; mem_rdt = '0;

        // ibus read: raised in IDLE, memory sees it next cycle
        ibus_cyc = 1'b1; ibus_adr = 32'h100;
        #1;
        chk("ib_cyc_n",     {31'd0, mem_cyc},  32'd0);
        tick;
        chk("ib_cyc_n1",    {31'd0, mem_cyc},  32'd1);
        chk("ib_adr",       mem_adr,           32'h100);
        chk("ib_sel",       {28'd0, mem_sel},  32'hf);
        chk("ib_we",        {31'd0, mem_we},   32'd0);
        tick;
        tick;
        chk("ib_wait_ack",  {31'd0, ibus_ack}, 32'd0);
        mem_ack = 1'b1; mem_rdt = 32'hdeadbeef;
        #1;
        chk("ib_ack",       {31'd0, ibus_ack}, 32'd1);
        chk("ib_rdt",       ibus_rdt,          32'hdeadbeef);
        chk("ib_dack",      {31'd0, dbus_ack}, 32'd0);
        chk("ib_drdt",      dbus_rdt,          32'd0);
        tick;
        ibus_cyc = 1'b0; mem_ack = 1'b0; mem_rdt = '0;
        #1;
        chk("ib_bubble",    {31'd0, mem_cyc},  32'd0);

        // dbus write
        dbus_cyc = 1'b1; dbus_adr = 32'h2000; dbus_dat = 32'h12345678;
        dbus_sel = 4'b0011; dbus_we = 1'b1;
        tick;
        chk("db_cyc",       {31'd0, mem_cyc},  32'd1);
        chk("db_adr",       mem_adr,           32'h2000);
        chk("db_dat",       mem_dat,           32'h12345678);
        chk("db_sel",       {28'd0, mem_sel},  32'h3);
        chk("db_we",        {31'd0, mem_we},   32'd1);
        mem_ack = 1'b1;
        #1;
        chk("db_ack",       {31'd0, dbus_ack}, 32'd1);
        chk("db_iack",      {31'd0, ibus_ack}, 32'd0);
        tick;
        dbus_cyc = 1'b0; dbus_we = 1'b0; mem_ack = 1'b0;
        #1;
        chk("db_bubble",    {31'd0, mem_cyc},  32'd0);

        // Reset while dbus waits for ack
        dbus_cyc = 1'b1; dbus_adr = 32'h2004; dbus_sel = 4'hf;
        tick;
        chk("rm_cyc",       {31'd0, mem_cyc},  32'd1);
        rst = 1'b1; mem_ack = 1'b1;
        #1;
        chk("rm_cyc_drop",  {31'd0, mem_cyc},  32'd0);
        chk("rm_no_ack",    {31'd0, dbus_ack}, 32'd0);
        tick;
        rst = 1'b0; mem_ack = 1'b0; dbus_cyc = 1'b0;
        ibus_cyc = 1'b1; ibus_adr = 32'h104;
        tick;
        chk("rm_ib_cyc",    {31'd0, mem_cyc},  32'd1);
        chk("rm_ib_adr",    mem_adr,           32'h104);
        mem_ack = 1'b1; mem_rdt = 32'hcafef00d;
        #1;
        chk("rm_ib_ack",    {31'd0, ibus_ack}, 32'd1);
        chk("rm_ib_rdt",    ibus_rdt,          32'hcafef00d);
        tick;
        ibus_cyc = 1'b0; mem_ack = 1'b0; mem_rdt = '0;

        // Both request, last_grant=IBUS on both instances
        ibus_cyc = 1'b1; ibus_adr = 32'h200;
        dbus_cyc = 1'b1; dbus_adr = 32'h3000; dbus_sel = 4'hf; dbus_we = 1'b0;
        tick;
        chk("rr_first",     mem_adr,           32'h3000);
        chk("rr0_first",    r0_mem_adr,        32'h3000);
        mem_ack = 1'b1; mem_rdt = 32'h11111111;
        #1;
        chk("rr_dack",      {31'd0, dbus_ack}, 32'd1);
        chk("rr_iack0",     {31'd0, ibus_ack}, 32'd0);
        tick;
        mem_ack = 1'b0;
        #1;
        chk("rr_bubble",    {31'd0, mem_cyc},  32'd0);
        chk("rr0_bubble",   {31'd0, r0_mem_cyc}, 32'd0);
        tick;
        chk("rr_second",    mem_adr,           32'h200);
        chk("rr_second_cyc",{31'd0, mem_cyc},  32'd1);
        chk("rr0_second",   r0_mem_adr,        32'h3000);
        mem_ack = 1'b1; mem_rdt = 32'h22222222;
        #1;
        chk("rr_iack",      {31'd0, ibus_ack}, 32'd1);
        chk("rr_irdt",      ibus_rdt,          32'h22222222);
        chk("rr0_dack",     {31'd0, r0_dbus_ack}, 32'd1);
        chk("rr0_iack",     {31'd0, r0_ibus_ack}, 32'd0);
        tick;
        mem_ack = 1'b0;
        tick;
        chk("rr_third",     mem_adr,           32'h3000);
        chk("rr0_third",    r0_mem_adr,        32'h3000);
        mem_ack = 1'b1;
        #1;
        chk("rr0_starve",   {31'd0, r0_ibus_ack}, 32'd0);
        chk("rr0_dack3",    {31'd0, r0_dbus_ack}, 32'd1);
        tick;
        mem_ack = 1'b0; ibus_cyc = 1'b0; dbus_cyc = 1'b0; mem_rdt = '0;
        tick;

        // ibus abort: cyc dropped before ack, late ack ignored
        ibus_cyc = 1'b1; ibus_adr = 32'h300;
        tick;
        chk("ab_cyc",       {31'd0, mem_cyc},  32'd1);
        ibus_cyc = 1'b0; mem_ack = 1'b1;
        #1;
        chk("ab_cyc_drop",  {31'd0, mem_cyc},  32'd0);
        chk("ab_no_ack",    {31'd0, ibus_ack}, 32'd0);
        tick;
        mem_ack = 1'b0;

`ifdef QERV_ARB_TIMEOUT_EN
        // Watchdog: no ack, forced termination in the 8th cycle
        tick;
        dbus_cyc = 1'b1; dbus_adr = 32'h4000; mem_rdt = 32'haaaa5555;
        tick;
        for (int i = 1; i < 8; i++) begin
            chk("to_wait_cyc", {31'd0, mem_cyc}, 32'd1);
            chk("to_wait_tmo", {31'd0, tmo},     32'd0);
            tick;
        end
        chk("to_ack",       {31'd0, dbus_ack}, 32'd1);
        chk("to_rdt",       dbus_rdt,          32'd0);
        chk("to_pulse",     {31'd0, tmo},      32'd1);
        chk("to_cyc",       {31'd0, mem_cyc},  32'd0);
        tick;
        dbus_cyc = 1'b0;
        #1;
        chk("to_idle_tmo",  {31'd0, tmo},      32'd0);
        chk("to_idle_cyc",  {31'd0, mem_cyc},  32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
